// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_flow_ctrl
// Description : Top-level game sequencer (IDLE -> CONFIG -> PLAY -> REPORT).
//               Owns song selection, play-frame timing, score/combo/life
//               accounting and the value shown on the 4-digit hex display.
// Revision    : 1.0 - initial release
// ============================================================================
module game_flow_ctrl #(
    parameter int          N_SONGS       = 4,
    parameter int          SONG_W        = 2,
    parameter int          REPORT_FRAMES = 600,
    parameter int          SCORE_PERFECT = 3,
    parameter int          SCORE_GOOD    = 1,
    parameter logic [9:0]  LIFE_MAX      = 10'd256,
    parameter int          LIFE_HIT      = 2,
    parameter int          LIFE_MISS     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic              key_start,
    input  logic              key_next,
    input  logic              key_prev,
    input  logic              key_abort,
    input  logic [15:0]       song_len,
    input  logic              hit_perfect,
    input  logic              hit_good,
    input  logic              hit_miss,
    output logic [1:0]        state,
    output logic [SONG_W-1:0] song_sel,
    output logic [15:0]       play_frame,
    output logic [15:0]       score,
    output logic [9:0]        combo,
    output logic [9:0]        max_combo,
    output logic [9:0]        life,
    output logic [15:0]       hex_val
);

    localparam logic [1:0] GST_STATE_IDLE   = 2'd0;
    localparam logic [1:0] GST_STATE_CONFIG = 2'd1;
    localparam logic [1:0] GST_STATE_PLAY   = 2'd2;
    localparam logic [1:0] GST_STATE_REPORT = 2'd3;

    localparam int CNT_W = $clog2(REPORT_FRAMES + 1);

    localparam logic [SONG_W-1:0] c_SONG_LAST     = SONG_W'(N_SONGS - 1);
    localparam logic [15:0]       c_SCORE_PERFECT = 16'(SCORE_PERFECT);
    localparam logic [15:0]       c_SCORE_GOOD    = 16'(SCORE_GOOD);
    localparam logic [10:0]       c_LIFE_HIT      = 11'(LIFE_HIT);
    localparam logic [9:0]        c_LIFE_MISS     = 10'(LIFE_MISS);
    localparam logic [CNT_W-1:0]  c_REPORT_FRAMES = CNT_W'(REPORT_FRAMES);

    logic [15:0]       r_len;
    logic [CNT_W-1:0]  r_report_cnt;

    logic [15:0]       w_pf_inc;
    logic [15:0]       w_score_add;
    logic [16:0]       w_score_sum;
    logic [10:0]       w_life_sum;
    logic [15:0]       w_score_nxt;
    logic [9:0]        w_combo_nxt;
    logic [9:0]        w_combo_inc;
    logic [9:0]        w_max_nxt;
    logic [9:0]        w_life_nxt;
    logic [SONG_W-1:0] w_song_up;
    logic [SONG_W-1:0] w_song_dn;
    logic [CNT_W-1:0]  w_rpt_inc;
    logic              w_frame_end;

    // Saturating increments and wrap-around song stepping.
    always_comb begin
        w_pf_inc    = (play_frame == 16'hFFFF) ? play_frame : play_frame + 16'd1;
        w_combo_inc = (combo == 10'd1023) ? combo : combo + 10'd1;
        w_song_up   = (song_sel == c_SONG_LAST) ? '0 : song_sel + SONG_W'(1);
        w_song_dn   = (song_sel == '0) ? c_SONG_LAST : song_sel - SONG_W'(1);
        w_rpt_inc   = r_report_cnt + CNT_W'(1);
        w_frame_end = frame_tick && (w_pf_inc >= r_len);
    end

    // Judgement outcome for this cycle; miss outranks perfect outranks good.
    always_comb begin
        w_score_add = hit_perfect ? c_SCORE_PERFECT : c_SCORE_GOOD;
        w_score_sum = {1'b0, score} + {1'b0, w_score_add};
        w_life_sum  = {1'b0, life} + c_LIFE_HIT;
        w_score_nxt = score;
        w_combo_nxt = combo;
        w_life_nxt  = life;
        if (hit_miss) begin
            w_combo_nxt = 10'd0;
            w_life_nxt  = (life > c_LIFE_MISS) ? life - c_LIFE_MISS : 10'd0;
        end else if (hit_perfect || hit_good) begin
            w_score_nxt = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
            w_combo_nxt = w_combo_inc;
            if (hit_perfect) begin
                w_life_nxt = (w_life_sum >= {1'b0, LIFE_MAX}) ? LIFE_MAX : w_life_sum[9:0];
            end
        end
        w_max_nxt = (w_combo_nxt > max_combo) ? w_combo_nxt : max_combo;
    end

    // Game state machine and all registered accounting.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= GST_STATE_IDLE;
            song_sel     <= '0;
            play_frame   <= 16'd0;
            score        <= 16'd0;
            combo        <= 10'd0;
            max_combo    <= 10'd0;
            life         <= LIFE_MAX;
            r_len        <= 16'd0;
            r_report_cnt <= '0;
        end else begin
            case (state)
                GST_STATE_IDLE: begin
                    if (key_start) state <= GST_STATE_CONFIG;
                end
                GST_STATE_CONFIG: begin
                    if (key_abort) begin
                        state <= GST_STATE_IDLE;
                    end else if (key_start) begin
                        state      <= GST_STATE_PLAY;
                        r_len      <= song_len;
                        play_frame <= 16'd0;
                        score      <= 16'd0;
                        combo      <= 10'd0;
                        max_combo  <= 10'd0;
                        life       <= LIFE_MAX;
                    end else if (key_next && !key_prev) begin
                        song_sel <= w_song_up;
                    end else if (key_prev && !key_next) begin
                        song_sel <= w_song_dn;
                    end
                end
                GST_STATE_PLAY: begin
                    if (frame_tick) play_frame <= w_pf_inc;
                    score     <= w_score_nxt;
                    combo     <= w_combo_nxt;
                    max_combo <= w_max_nxt;
                    life      <= w_life_nxt;
                    if (key_abort) begin
                        state <= GST_STATE_IDLE;
                    end else if (w_frame_end || (w_life_nxt == 10'd0)) begin
                        state        <= GST_STATE_REPORT;
                        r_report_cnt <= '0;
                    end
                end
                default: begin
                    // REPORT: accounting frozen, only the dwell counter runs.
                    if (key_abort || key_start) begin
                        state <= GST_STATE_IDLE;
                    end else if (frame_tick) begin
                        if (w_rpt_inc >= c_REPORT_FRAMES) state <= GST_STATE_IDLE;
                        r_report_cnt <= w_rpt_inc;
                    end
                end
            endcase
        end
    end

    // Display mux: a pure function of registered state.
    always_comb begin
        case (state)
            GST_STATE_CONFIG: hex_val = {{(16-SONG_W){1'b0}}, song_sel};
            GST_STATE_PLAY:   hex_val = score;
            GST_STATE_REPORT: hex_val = {6'd0, max_combo};
            default:          hex_val = 16'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_flow_ctrl
// Description : Self-checking bench for game_flow_ctrl (vector table plus
//               hand-written multi-cycle sequences, scoreboard queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_flow_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CFG  = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_RPT  = 2'd3;

    // key bits: start next prev abort tick perfect good miss
    localparam logic [7:0] K_NONE  = 8'h00;
    localparam logic [7:0] K_START = 8'h80;
    localparam logic [7:0] K_NEXT  = 8'h40;
    localparam logic [7:0] K_PREV  = 8'h20;
    localparam logic [7:0] K_ABORT = 8'h10;
    localparam logic [7:0] K_TICK  = 8'h08;
    localparam logic [7:0] K_PERF  = 8'h04;
    localparam logic [7:0] K_GOOD  = 8'h02;
    localparam logic [7:0] K_MISS  = 8'h01;

    typedef struct {
        logic        rst;
        logic [7:0]  keys;
        logic [15:0] len;
        logic [1:0]  st;
        logic [1:0]  song;
        logic [15:0] pf;
        logic [15:0] sc;
        logic [9:0]  cb;
        logic [9:0]  mc;
        logic [9:0]  lf;
        logic [15:0] hx;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_tick = 1'b0, key_start = 1'b0, key_next = 1'b0;
    logic        key_prev = 1'b0, key_abort = 1'b0;
    logic [15:0] song_len = 16'd0;
    logic        hit_perfect = 1'b0, hit_good = 1'b0, hit_miss = 1'b0;
    logic [1:0]  state;
    logic [1:0]  song_sel;
    logic [15:0] play_frame, score, hex_val;
    logic [9:0]  combo, max_combo, life;

    int checks = 0;
    int errors = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    game_flow_ctrl #(
        .N_SONGS(4), .SONG_W(2), .REPORT_FRAMES(4), .SCORE_PERFECT(3),
        .SCORE_GOOD(1), .LIFE_MAX(10'd256), .LIFE_HIT(2), .LIFE_MISS(16)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .key_start(key_start),
        .key_next(key_next), .key_prev(key_prev), .key_abort(key_abort),
        .song_len(song_len), .hit_perfect(hit_perfect), .hit_good(hit_good),
        .hit_miss(hit_miss), .state(state), .song_sel(song_sel),
        .play_frame(play_frame), .score(score), .combo(combo),
        .max_combo(max_combo), .life(life), .hex_val(hex_val)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic [7:0] keys, logic [15:0] len, logic [1:0] st,
                                logic [1:0] song, logic [15:0] pf, logic [15:0] sc,
                                logic [9:0] cb, logic [9:0] mc, logic [9:0] lf,
                                logic [15:0] hx);
        vec_t v;
        v.rst = 1'b0; v.keys = keys; v.len = len; v.st = st; v.song = song;
        v.pf = pf; v.sc = sc; v.cb = cb; v.mc = mc; v.lf = lf; v.hx = hx;
        return v;
    endfunction

    task automatic chk(string name, int step_no, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step %0d %s: got %0d required %0d", step_no, name, act, req);
        end
    endtask

    // Push expectation, drive one cycle of stimulus, pop and compare after the edge.
    task automatic step(vec_t v, int step_no);
        vec_t e;
        exp_q.push_back(v);
        @(negedge Clk);
        Reset       = v.rst;
        key_start   = v.keys[7];
        key_next    = v.keys[6];
        key_prev    = v.keys[5];
        key_abort   = v.keys[4];
        frame_tick  = v.keys[3];
        hit_perfect = v.keys[2];
        hit_good    = v.keys[1];
        hit_miss    = v.keys[0];
        song_len    = v.len;
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        chk("state",      step_no, {14'd0, state},     {14'd0, e.st});
        chk("song_sel",   step_no, {14'd0, song_sel},  {14'd0, e.song});
        chk("play_frame", step_no, play_frame,         e.pf);
        chk("score",      step_no, score,              e.sc);
        chk("combo",      step_no, {6'd0, combo},      {6'd0, e.cb});
        chk("max_combo",  step_no, {6'd0, max_combo},  {6'd0, e.mc});
        chk("life",       step_no, {6'd0, life},       {6'd0, e.lf});
        chk("hex_val",    step_no, hex_val,            e.hx);
    endtask

    initial begin
        vec_t v;
        int n;

        // keys len st song pf sc cb mc life hex
        tbl.push_back(mk(K_START, 0, S_CFG, 0, 0, 0, 0, 0, 256, 0));
        tbl.push_back(mk(K_NEXT,  0, S_CFG, 1, 0, 0, 0, 0, 256, 1));
        tbl.push_back(mk(K_NEXT,  0, S_CFG, 2, 0, 0, 0, 0, 256, 2));
        tbl.push_back(mk(K_NEXT,  0, S_CFG, 3, 0, 0, 0, 0, 256, 3));
        tbl.push_back(mk(K_NEXT,  0, S_CFG, 0, 0, 0, 0, 0, 256, 0));
        tbl.push_back(mk(K_NEXT,  0, S_CFG, 1, 0, 0, 0, 0, 256, 1));
        tbl.push_back(mk(K_PREV,  0, S_CFG, 0, 0, 0, 0, 0, 256, 0));
        tbl.push_back(mk(K_PREV,  0, S_CFG, 3, 0, 0, 0, 0, 256, 3));
        tbl.push_back(mk(K_NEXT | K_PREV, 0, S_CFG, 3, 0, 0, 0, 0, 256, 3));
        tbl.push_back(mk(K_START, 3, S_PLAY, 3, 0, 0, 0, 0, 256, 0));
        tbl.push_back(mk(K_PERF,  3, S_PLAY, 3, 0, 3, 1, 1, 256, 3));
        tbl.push_back(mk(K_PERF,  3, S_PLAY, 3, 0, 6, 2, 2, 256, 6));
        tbl.push_back(mk(K_GOOD,  3, S_PLAY, 3, 0, 7, 3, 3, 256, 7));
        tbl.push_back(mk(K_MISS,  3, S_PLAY, 3, 0, 7, 0, 3, 240, 7));
        tbl.push_back(mk(K_PERF,  3, S_PLAY, 3, 0, 10, 1, 3, 242, 10));
        tbl.push_back(mk(K_TICK,  3, S_PLAY, 3, 1, 10, 1, 3, 242, 10));
        tbl.push_back(mk(K_TICK,  3, S_PLAY, 3, 2, 10, 1, 3, 242, 10));
        tbl.push_back(mk(K_TICK | K_PERF, 3, S_RPT, 3, 3, 13, 2, 3, 244, 3));
        tbl.push_back(mk(K_PERF,  3, S_RPT, 3, 3, 13, 2, 3, 244, 3));
        tbl.push_back(mk(K_TICK,  3, S_RPT, 3, 3, 13, 2, 3, 244, 3));
        tbl.push_back(mk(K_TICK,  3, S_RPT, 3, 3, 13, 2, 3, 244, 3));
        tbl.push_back(mk(K_TICK,  3, S_RPT, 3, 3, 13, 2, 3, 244, 3));
        tbl.push_back(mk(K_TICK,  3, S_IDLE, 3, 3, 13, 2, 3, 244, 0));
        tbl.push_back(mk(K_NEXT,  3, S_IDLE, 3, 3, 13, 2, 3, 244, 0));
        tbl.push_back(mk(K_START, 3, S_CFG, 3, 3, 13, 2, 3, 244, 3));
        tbl.push_back(mk(K_ABORT, 3, S_IDLE, 3, 3, 13, 2, 3, 244, 0));
        tbl.push_back(mk(K_START, 3, S_CFG, 3, 3, 13, 2, 3, 244, 3));
        tbl.push_back(mk(K_START, 0, S_PLAY, 3, 0, 0, 0, 0, 256, 0));
        tbl.push_back(mk(K_TICK,  0, S_RPT, 3, 1, 0, 0, 0, 256, 0));
        tbl.push_back(mk(K_TICK,  0, S_RPT, 3, 1, 0, 0, 0, 256, 0));
        tbl.push_back(mk(K_START, 0, S_IDLE, 3, 1, 0, 0, 0, 256, 0));
        tbl.push_back(mk(K_START, 0, S_CFG, 3, 1, 0, 0, 0, 256, 3));
        tbl.push_back(mk(K_START, 100, S_PLAY, 3, 0, 0, 0, 0, 256, 0));
        tbl.push_back(mk(K_GOOD | K_TICK, 100, S_PLAY, 3, 1, 1, 1, 1, 256, 1));
        tbl.push_back(mk(K_ABORT, 100, S_IDLE, 3, 1, 1, 1, 1, 256, 0));

        // Reset held: outputs must show reset values.
        v = mk(K_NONE, 0, S_IDLE, 0, 0, 0, 0, 0, 256, 0);
        v.rst = 1'b1;
        step(v, 0);
        @(negedge Clk);
        Reset = 1'b0;

        n = 1;
        foreach (tbl[i]) begin
            step(tbl[i], n);
            n++;
        end

        // Life drains to zero: 16 misses, REPORT on the edge life hits 0.
        step(mk(K_START, 0, S_CFG, 3, 1, 1, 1, 1, 256, 3), n); n++;
        step(mk(K_START, 1000, S_PLAY, 3, 0, 0, 0, 0, 256, 0), n); n++;
        for (int i = 1; i <= 16; i++) begin
            step(mk(K_MISS, 1000, (i == 16) ? S_RPT : S_PLAY, 3, 0, 0, 0, 0,
                    10'(256 - 16 * i), 0), n);
            n++;
        end
        step(mk(K_MISS, 1000, S_RPT, 3, 0, 0, 0, 0, 0, 0), n); n++;
        step(mk(K_ABORT, 1000, S_IDLE, 3, 0, 0, 0, 0, 0, 0), n); n++;

        // Reset in the middle of a play with score 10 / life 242.
        step(mk(K_START, 0, S_CFG, 3, 0, 0, 0, 0, 0, 3), n); n++;
        step(mk(K_START, 1000, S_PLAY, 3, 0, 0, 0, 0, 256, 0), n); n++;
        step(mk(K_PERF, 1000, S_PLAY, 3, 0, 3, 1, 1, 256, 3), n); n++;
        step(mk(K_PERF, 1000, S_PLAY, 3, 0, 6, 2, 2, 256, 6), n); n++;
        step(mk(K_GOOD | K_TICK, 1000, S_PLAY, 3, 1, 7, 3, 3, 256, 7), n); n++;
        step(mk(K_MISS, 1000, S_PLAY, 3, 1, 7, 0, 3, 240, 7), n); n++;
        step(mk(K_PERF, 1000, S_PLAY, 3, 1, 10, 1, 3, 242, 10), n); n++;
        v = mk(K_PERF | K_TICK | K_START, 1000, S_IDLE, 0, 0, 0, 0, 0, 256, 0);
        v.rst = 1'b1;
        step(v, n); n++;

        @(negedge Clk);
        Reset = 1'b0; key_start = 1'b0; frame_tick = 1'b0; hit_perfect = 1'b0;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: got %0d pending entries required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
